// File: rtl/ctrl_oven_if.sv
// Oven controller signal bundle: user/counter requests in, lamp/power/counter controls out.
interface ctrl_oven_if;
    logic half_power;
    logic full_power;
    logic s30;
    logic s60;
    logic s120;
    logic time_set;
    logic door_open;
    logic start;
    logic timeout;
    logic full;
    logic half;
    logic in_light;
    logic finished;
    logic start_count;
    logic stop_count;

    modport master (
        output half_power, full_power, s30, s60, s120, time_set, door_open, start, timeout,
        input  full, half, in_light, finished, start_count, stop_count
    );

    modport slave (
        input  half_power, full_power, s30, s60, s120, time_set, door_open, start, timeout,
        output full, half, in_light, finished, start_count, stop_count
    );
endinterface

// File: rtl/ctrl_oven.sv
// Microwave oven sequencing FSM: power select, time select, door interlock, cook and complete.
// Outputs are registered from the next state so they move on the same edge as the state.
//
// state       | meaning
// IDLE        | no power selected, waiting for a power request
// FULL_PWR    | full power chosen, waiting for a time selection
// HALF_PWR    | half power chosen, waiting for a time selection
// SET_TIME    | one-cycle latch of the time selection
// OP_DISABLED | door open, lamp on, counter paused
// OP_ENABLED  | door closed, waiting for start
// OPERATING   | cooking, external counter running
// COMPLETE    | cook time elapsed, waiting for door open
module ctrl_oven (
    input  logic         clk,
    input  logic         reset,
    ctrl_oven_if.slave   bus
);

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        FULL_PWR    = 3'd1,
        HALF_PWR    = 3'd2,
        SET_TIME    = 3'd3,
        OP_DISABLED = 3'd4,
        OP_ENABLED  = 3'd5,
        OPERATING   = 3'd6,
        COMPLETE    = 3'd7
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   time_sel;

    assign time_sel = bus.time_set & (bus.s30 | bus.s60 | bus.s120);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.full_power)      state_nxt = FULL_PWR;
                else if (bus.half_power) state_nxt = HALF_PWR;
            end
            FULL_PWR: begin
                if (bus.half_power && !bus.full_power) state_nxt = HALF_PWR;
                else if (time_sel)                     state_nxt = SET_TIME;
            end
            HALF_PWR: begin
                if (bus.full_power) state_nxt = FULL_PWR;
                else if (time_sel)  state_nxt = SET_TIME;
            end
            SET_TIME: begin
                state_nxt = bus.door_open ? OP_DISABLED : OP_ENABLED;
            end
            OP_ENABLED: begin
                if (bus.door_open)  state_nxt = OP_DISABLED;
                else if (bus.start) state_nxt = OPERATING;
            end
            OP_DISABLED: begin
                if (!bus.door_open) state_nxt = OP_ENABLED;
            end
            OPERATING: begin
                // an open door must win over a coincident timeout
                if (bus.door_open)    state_nxt = OP_DISABLED;
                else if (bus.timeout) state_nxt = COMPLETE;
            end
            COMPLETE: begin
                if (bus.door_open) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            bus.full        <= 1'b0;
            bus.half        <= 1'b0;
            bus.in_light    <= 1'b0;
            bus.finished    <= 1'b0;
            bus.start_count <= 1'b0;
            bus.stop_count  <= 1'b1;
        end else begin
            state <= state_nxt;
            // power indication persists through the cook cycle until IDLE
            case (state_nxt)
                IDLE: begin
                    bus.full <= 1'b0;
                    bus.half <= 1'b0;
                end
                FULL_PWR: begin
                    bus.full <= 1'b1;
                    bus.half <= 1'b0;
                end
                HALF_PWR: begin
                    bus.full <= 1'b0;
                    bus.half <= 1'b1;
                end
                default: begin
                    bus.full <= bus.full;
                    bus.half <= bus.half;
                end
            endcase
            bus.in_light    <= (state_nxt == OP_DISABLED) || (state_nxt == OPERATING);
            bus.finished    <= (state_nxt == COMPLETE);
            bus.start_count <= (state_nxt == OPERATING) && (state != OPERATING);
            bus.stop_count  <= (state_nxt != OPERATING);
        end
    end

endmodule

// File: tb/tb_ctrl_oven.sv
// Table-driven bench for ctrl_oven with an expected-output scoreboard queue.
module tb_ctrl_oven;

    logic clk = 1'b0;
    logic reset;

    ctrl_oven_if bus ();

    ctrl_oven dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // input bits: {reset, full_power, half_power, s30, s60, s120, time_set, door_open, start, timeout}
    localparam logic [9:0] I_RN   = 10'b1000000000;
    localparam logic [9:0] I_FP   = 10'b0100000000;
    localparam logic [9:0] I_HP   = 10'b0010000000;
    localparam logic [9:0] I_S30  = 10'b0001000000;
    localparam logic [9:0] I_S60  = 10'b0000100000;
    localparam logic [9:0] I_S120 = 10'b0000010000;
    localparam logic [9:0] I_TS   = 10'b0000001000;
    localparam logic [9:0] I_DOOR = 10'b0000000100;
    localparam logic [9:0] I_ST   = 10'b0000000010;
    localparam logic [9:0] I_TMO  = 10'b0000000001;

    // output bits: {full, half, in_light, finished, start_count, stop_count}
    localparam logic [5:0] O_IDLE  = 6'b000001;
    localparam logic [5:0] O_FULL  = 6'b100001;
    localparam logic [5:0] O_HALF  = 6'b010001;
    localparam logic [5:0] O_FDIS  = 6'b101001;
    localparam logic [5:0] O_FRUN1 = 6'b101010;
    localparam logic [5:0] O_FRUN  = 6'b101000;
    localparam logic [5:0] O_FDONE = 6'b100101;
    localparam logic [5:0] O_HDIS  = 6'b011001;
    localparam logic [5:0] O_HRUN1 = 6'b011010;

    typedef struct {
        string      name;
        logic [9:0] in;
        logic [5:0] exp;
    } vec_t;

    typedef struct {
        string      name;
        logic [5:0] exp;
    } sb_t;

    vec_t vecs[$];
    sb_t  sb_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic add(input string n, input logic [9:0] i, input logic [5:0] e);
        vec_t v;
        v.name = n;
        v.in   = i;
        v.exp  = e;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic [9:0] i);
        {reset, bus.full_power, bus.half_power, bus.s30, bus.s60, bus.s120,
         bus.time_set, bus.door_open, bus.start, bus.timeout} = i;
    endtask

    task automatic expect_out(input string n, input logic [5:0] e);
        sb_t s;
        s.name = n;
        s.exp  = e;
        sb_q.push_back(s);
    endtask

    task automatic check_pop();
        sb_t        s;
        logic [5:0] got;
        got = {bus.full, bus.half, bus.in_light, bus.finished, bus.start_count, bus.stop_count};
        total++;
        if (sb_q.size() == 0) begin
            bad++;
            $display("FAIL sb_empty: got=%b want=<queued entry>", got);
        end else begin
            s = sb_q.pop_front();
            if (got !== s.exp) begin
                bad++;
                $display("FAIL %s: got=%b want=%b (full half light fin start_cnt stop_cnt)",
                         s.name, got, s.exp);
            end
        end
    endtask

    task automatic step(input vec_t v);
        drive(v.in);
        expect_out(v.name, v.exp);
        @(posedge clk);
        #1;
        check_pop();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // basic full-power cook with door open before start
        add("reset",          10'b0,                         O_IDLE);
        add("idle_hold",      I_RN,                          O_IDLE);
        add("to_full",        I_RN | I_FP,                   O_FULL);
        add("set_time30",     I_RN | I_S30 | I_TS,           O_FULL);
        add("op_enabled",     I_RN,                          O_FULL);
        add("op_en_hold",     I_RN,                          O_FULL);
        add("door_open",      I_RN | I_DOOR,                 O_FDIS);
        add("door_close",     I_RN | I_ST,                   O_FULL);
        add("run_start",      I_RN | I_ST,                   O_FRUN1);
        for (int k = 0; k < 29; k++)
            add("run_hold",   I_RN | I_ST,                   O_FRUN);
        add("timeout",        I_RN | I_ST | I_TMO,           O_FDONE);
        add("complete_hold",  I_RN,                          O_FDONE);
        add("complete_door",  I_RN | I_DOOR,                 O_IDLE);
        add("idle_after",     I_RN,                          O_IDLE);

        // power toggling, pause/resume on door
        add("p_full",         I_RN | I_FP,                   O_FULL);
        add("p_half",         I_RN | I_HP,                   O_HALF);
        add("p_full2",        I_RN | I_FP,                   O_FULL);
        add("p_both_in_full", I_RN | I_FP | I_HP,            O_FULL);
        add("p_half2",        I_RN | I_HP,                   O_HALF);
        add("p_both_in_half", I_RN | I_FP | I_HP,            O_FULL);
        add("set_time120",    I_RN | I_S120 | I_TS,          O_FULL);
        add("op_en2",         I_RN | I_ST,                   O_FULL);
        add("run2_start",     I_RN | I_ST,                   O_FRUN1);
        for (int k = 0; k < 5; k++)
            add("run2_hold",  I_RN | I_ST,                   O_FRUN);
        for (int k = 0; k < 10; k++)
            add("pause_door", I_RN | I_ST | I_DOOR,          O_FDIS);
        add("pause_close",    I_RN | I_ST,                   O_FULL);
        add("resume_start",   I_RN | I_ST,                   O_FRUN1);
        for (int k = 0; k < 3; k++)
            add("resume_hold", I_RN | I_ST,                  O_FRUN);
        add("timeout2",       I_RN | I_ST | I_TMO,           O_FDONE);
        add("done2_door",     I_RN | I_DOOR,                 O_IDLE);

        // half power with all selections and door open at once
        add("h_half",         I_RN | I_HP,                   O_HALF);
        add("h_all_set",      I_RN | I_HP | I_S60 | I_TS | I_ST | I_DOOR, O_HALF);
        add("h_all_dis",      I_RN | I_HP | I_S60 | I_TS | I_ST | I_DOOR, O_HDIS);
        add("h_close",        I_RN | I_ST,                   O_HALF);
        add("h_run",          I_RN | I_ST,                   O_HRUN1);
        // door wins over coincident timeout, then reset from OP_DISABLED
        add("tmo_door",       I_RN | I_ST | I_TMO | I_DOOR,  O_HDIS);
        add("tmo_door_hold",  I_RN | I_DOOR,                 O_HDIS);
        add("rst_in_dis",     I_DOOR,                        O_IDLE);
        add("rst_dis_rel",    I_RN,                          O_IDLE);

        // reset in OP_ENABLED
        add("e_full",         I_RN | I_FP,                   O_FULL);
        add("e_set",          I_RN | I_S30 | I_TS,           O_FULL);
        add("e_op_en",        I_RN,                          O_FULL);
        add("rst_in_en",      10'b0,                         O_IDLE);
        add("rst_en_rel",     I_RN | I_ST,                   O_IDLE);

        // reset in OPERATING, no stale power afterwards
        add("o_full",         I_RN | I_FP,                   O_FULL);
        add("o_set",          I_RN | I_S60 | I_TS,           O_FULL);
        add("o_op_en",        I_RN | I_ST,                   O_FULL);
        add("o_run",          I_RN | I_ST,                   O_FRUN1);
        add("o_run_hold",     I_RN | I_ST,                   O_FRUN);
        add("rst_in_run",     I_ST,                          O_IDLE);
        add("rst_run_rel",    I_RN | I_ST,                   O_IDLE);
        add("o_half_fresh",   I_RN | I_HP,                   O_HALF);

        // selection without time_set must not advance
        add("n_full",         I_RN | I_FP,                   O_FULL);
        for (int k = 0; k < 5; k++)
            add("no_time_set", I_RN | I_S30,                 O_FULL);
        add("no_ts_start",    I_RN | I_S30 | I_ST,           O_FULL);
        add("n_set",          I_RN | I_S30 | I_TS,           O_FULL);
        add("n_op_en",        I_RN | I_ST,                   O_FULL);
        add("n_run",          I_RN | I_ST,                   O_FRUN1);
        add("n_run_hold",     I_RN | I_ST,                   O_FRUN);

        foreach (vecs[k]) step(vecs[k]);

        // reset must act between clock edges
        #3;
        reset = 1'b0;
        expect_out("async_reset", O_IDLE);
        #1;
        check_pop();
        begin
            vec_t v;
            v.name = "async_rel";    v.in = I_RN;        v.exp = O_IDLE; step(v);
            v.name = "async_half";   v.in = I_RN | I_HP; v.exp = O_HALF; step(v);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
